// File: rtl/tmds_encoder_rgb.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_encoder_rgb
//  Purpose  : Three-channel DVI/TMDS 8b/10b encoder. Each channel converts an
//             8-bit pixel byte, or a 2-bit control word during blanking, into
//             a DC-balanced 10-bit symbol. A running disparity is tracked per
//             channel. The datapath is a fixed 2-stage pipeline:
//               stage 1 : transition-minimising q_m word (XOR/XNOR chain)
//               stage 2 : DC balancing, or control-symbol selection
//  Ports    : i_pix_clk            pixel clock, rising edge
//             i_rst_n              asynchronous active-low reset
//             i_red/green/blue     8-bit pixel, used while i_de=1
//             i_hsync, i_vsync     syncs, carried on the blue channel as C0/C1
//             i_de                 data enable (1 = active video)
//             o_tmds_ch0/1/2       blue / green / red 10-bit symbols
//             o_de                 i_de aligned with the symbols
//  Params   : P_SYNC_INVERT        1 = invert hsync/vsync before encoding
//  Revision : 1.0  initial release
// ============================================================================
module tmds_encoder_rgb #(
    parameter bit P_SYNC_INVERT = 1'b0
) (
    input  logic       i_pix_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_de,
    output logic [9:0] o_tmds_ch0,
    output logic [9:0] o_tmds_ch1,
    output logic [9:0] o_tmds_ch2,
    output logic       o_de
);

    // Control symbols indexed by {C1,C0}
    localparam logic [9:0] C_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] C_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] C_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] C_CTRL_11 = 10'b1010101011;

    // Channel-indexed views: index 0 = blue, 1 = green, 2 = red
    logic [2:0][7:0] w_data;
    logic [2:0][1:0] w_ctrl;

    assign w_data = {i_red, i_green, i_blue};
    // Only the blue channel carries sync; green and red always send 00
    assign w_ctrl = {2'b00, 2'b00, i_vsync ^ P_SYNC_INVERT, i_hsync ^ P_SYNC_INVERT};

    // Data-enable pipeline, shared by all three channels
    logic r_de_s1;
    logic r_de_s2;

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_de_s1 <= 1'b0;
            r_de_s2 <= 1'b0;
        end else begin
            r_de_s1 <= i_de;
            r_de_s2 <= r_de_s1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [3:0]        w_n1_d;
        logic              w_use_xnor;
        logic [8:0]        w_qm;
        logic [8:0]        r_qm;
        logic [1:0]        r_ctrl;
        logic [3:0]        w_n1_q;
        logic signed [4:0] w_bal;      // N1 - N0 of q_m[7:0]
        logic [9:0]        w_sym_nxt;
        logic signed [4:0] w_cnt_nxt;
        logic [9:0]        r_sym;
        logic signed [4:0] r_cnt;

        // Stage 1: pick the chain that minimises transitions
        always_comb begin : p_stage1
            logic [7:0] v_q;
            w_n1_d = '0;
            for (int i = 0; i < 8; i++) begin
                w_n1_d = w_n1_d + {3'b000, w_data[gi][i]};
            end
            w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !w_data[gi][0]);
            v_q[0] = w_data[gi][0];
            for (int i = 1; i < 8; i++) begin
                v_q[i] = w_use_xnor ? ~(v_q[i-1] ^ w_data[gi][i])
                                    :  (v_q[i-1] ^ w_data[gi][i]);
            end
            w_qm = {~w_use_xnor, v_q};
        end

        always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_qm   <= '0;
                r_ctrl <= 2'b00;
            end else begin
                r_qm   <= w_qm;
                r_ctrl <= w_ctrl[gi];
            end
        end

        // Stage 2: DC balancing. All disparity terms are 5-bit signed; the
        // running value is bounded to [-10,+10] so modular 5-bit arithmetic
        // on intermediate sums still lands on the exact result.
        always_comb begin
            w_n1_q = '0;
            for (int i = 0; i < 8; i++) begin
                w_n1_q = w_n1_q + {3'b000, r_qm[i]};
            end
            w_bal     = $signed({1'b0, w_n1_q}) - $signed({1'b0, 4'd8 - w_n1_q});
            w_sym_nxt = C_CTRL_00;
            w_cnt_nxt = r_cnt;
            if (!r_de_s1) begin
                w_cnt_nxt = 5'sd0;
                case (r_ctrl)
                    2'b00:   w_sym_nxt = C_CTRL_00;
                    2'b01:   w_sym_nxt = C_CTRL_01;
                    2'b10:   w_sym_nxt = C_CTRL_10;
                    default: w_sym_nxt = C_CTRL_11;
                endcase
            end else if ((r_cnt == 5'sd0) || (w_bal == 5'sd0)) begin
                w_sym_nxt = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_nxt = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
            end else if (((r_cnt > 5'sd0) && (w_bal > 5'sd0)) ||
                         ((r_cnt < 5'sd0) && (w_bal < 5'sd0))) begin
                // Current word would push disparity further the same way: invert it
                w_sym_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_bal;
            end else begin
                w_sym_nxt = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_bal - (r_qm[8] ? 5'sd0 : 5'sd2);
            end
        end

        always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sym <= C_CTRL_00;
                r_cnt <= 5'sd0;
            end else begin
                r_sym <= w_sym_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign o_tmds_ch0 = g_ch[0].r_sym;
    assign o_tmds_ch1 = g_ch[1].r_sym;
    assign o_tmds_ch2 = g_ch[2].r_sym;
    assign o_de       = r_de_s2;

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder_rgb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_encoder_rgb
//  Purpose  : Self-checking bench for tmds_encoder_rgb. Two instances share
//             the stimulus: one with sync inversion off, one with it on.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmds_encoder_rgb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] r, g, b;
    logic       hs, vs, de;
    logic [9:0] a0, a1, a2, i0, i1, i2;
    logic       ade, ide;

    always #5 clk = ~clk;

    tmds_encoder_rgb #(.P_SYNC_INVERT(1'b0)) dut_n (
        .i_pix_clk(clk), .i_rst_n(rst_n),
        .i_red(r), .i_green(g), .i_blue(b),
        .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .o_tmds_ch0(a0), .o_tmds_ch1(a1), .o_tmds_ch2(a2), .o_de(ade)
    );

    tmds_encoder_rgb #(.P_SYNC_INVERT(1'b1)) dut_i (
        .i_pix_clk(clk), .i_rst_n(rst_n),
        .i_red(r), .i_green(g), .i_blue(b),
        .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .o_tmds_ch0(i0), .o_tmds_ch1(i1), .o_tmds_ch2(i2), .o_de(ide)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic d, input logic h, input logic v,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        de = d; hs = h; vs = v; r = rr; g = gg; b = bb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // ---------------- reference model of the encoding algorithm -------------
    int m_cnt [3];

    function automatic int ones8(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    task automatic model(input int ch, input logic d_e, input logic [1:0] c,
                         input logic [7:0] d, output logic [9:0] sym);
        logic [8:0] q;
        int n1, n0;
        logic xn;
        n1 = ones8(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        if (!d_e) begin
            m_cnt[ch] = 0;
            case (c)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else begin
            n1 = ones8(q[7:0]);
            n0 = 8 - n1;
            if (m_cnt[ch] == 0 || n1 == n0) begin
                sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                m_cnt[ch] += q[8] ? (n1 - n0) : (n0 - n1);
            end else if ((m_cnt[ch] > 0 && n1 > n0) || (m_cnt[ch] < 0 && n0 > n1)) begin
                sym = {1'b1, q[8], ~q[7:0]};
                m_cnt[ch] += 2 * int'(q[8]) + n0 - n1;
            end else begin
                sym = {1'b0, q[8], q[7:0]};
                m_cnt[ch] += n1 - n0 - (q[8] ? 0 : 2);
            end
        end
    endtask

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] d, o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
        logic [9:0] e0i;
    } vec_t;

    vec_t vt [8];

    // hand-written stream: disparity sequence then a 1-cycle de drop
    logic       s_de  [10];
    logic [9:0] s_exp [10];

    // history for the random phase (slot = drive step mod 4)
    logic [9:0] he0 [4];
    logic [9:0] he1 [4];
    logic [9:0] he2 [4];
    logic       hde [4];
    logic [7:0] hr  [4];
    logic [7:0] hg  [4];
    logic [7:0] hb  [4];
    int         disp [3];

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 10'h2AB};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 10'h0AB, 10'h354, 10'h354, 10'h154};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hA5, 10'h154, 10'h354, 10'h354, 10'h0AB};
        vt[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 10'h2AB, 10'h354, 10'h354, 10'h354};
        vt[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 10'h200, 10'h200, 10'h200, 10'h200};
        vt[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h100, 10'h100, 10'h100, 10'h100};
        vt[6] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h01, 10'h1FF, 10'h133, 10'h233, 10'h1FF};
        vt[7] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h01, 10'h1FF, 10'h200, 10'h100, 10'h1FF};

        s_de  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        s_exp = '{10'h354, 10'h354, 10'h100, 10'h3FF, 10'h100, 10'h3FF,
                  10'h354, 10'h100, 10'h354, 10'h354};

        // ---- reset held for 3 clocks with arbitrary inputs ----
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'hC3, 8'h99);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst ch0", a0, 10'h354);
            chk("rst ch1", a1, 10'h354);
            chk("rst ch2", a2, 10'h354);
            chk("rst o_de", {9'b0, ade}, 10'h000);
            chk("rst inv ch0", i0, 10'h354);
            drive(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post-rst ch0", a0, 10'h354);
        chk("post-rst ch1", a1, 10'h354);
        chk("post-rst ch2", a2, 10'h354);

        // ---- table: each vector isolated between idle periods (cnt=0) ----
        for (int i = 0; i < 8; i++) begin
            idle();
            repeat (2) @(posedge clk);
            #1;
            drive(vt[i].de, vt[i].hs, vt[i].vs, vt[i].r, vt[i].g, vt[i].b);
            @(posedge clk); #1;
            idle();
            @(posedge clk); #1;
            chk($sformatf("vec%0d ch0", i), a0, vt[i].e0);
            chk($sformatf("vec%0d ch1", i), a1, vt[i].e1);
            chk($sformatf("vec%0d ch2", i), a2, vt[i].e2);
            chk($sformatf("vec%0d o_de", i), {9'b0, ade}, {9'b0, vt[i].de});
            chk($sformatf("vec%0d inv ch0", i), i0, vt[i].e0i);
            chk($sformatf("vec%0d inv ch1", i), i1, vt[i].e1);
        end
        idle();
        repeat (2) @(posedge clk);

        // ---- disparity sequence and de toggle, streamed one per clock ----
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (t >= 2) begin
                chk($sformatf("seq%0d ch0", t - 2), a0, s_exp[t-2]);
                chk($sformatf("seq%0d ch1", t - 2), a1, s_exp[t-2]);
                chk($sformatf("seq%0d ch2", t - 2), a2, s_exp[t-2]);
                chk($sformatf("seq%0d o_de", t - 2), {9'b0, ade}, {9'b0, s_de[t-2]});
            end
            if (t < 10) drive(s_de[t], 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            else idle();
        end

        // ---- reset asserted mid-line: immediate reversion, clean restart ----
        drive(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h01);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst ch0", a0, 10'h354);
        chk("async rst ch1", a1, 10'h354);
        chk("async rst ch2", a2, 10'h354);
        chk("async rst o_de", {9'b0, ade}, 10'h000);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release ch0", a0, 10'h354);
        idle();
        @(posedge clk); #1;
        chk("release first ch0", a0, 10'h100);
        chk("release first ch2", a2, 10'h100);
        chk("release first o_de", {9'b0, ade}, 10'h001);
        idle();
        repeat (2) @(posedge clk);

        // ---- random pixels against the model ----
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            disp[c]  = 0;
        end
        for (int k = 0; k < 4; k++) begin
            he0[k] = 10'h354; he1[k] = 10'h354; he2[k] = 10'h354;
            hde[k] = 1'b0; hr[k] = 8'h00; hg[k] = 8'h00; hb[k] = 8'h00;
        end
        for (int t = 0; t < 10002; t++) begin
            @(posedge clk); #1;
            if (t >= 2) begin
                int k;
                logic [9:0] sy [3];
                k = (t - 2) % 4;
                sy[0] = a0; sy[1] = a1; sy[2] = a2;
                chk("rnd ch0", a0, he0[k]);
                chk("rnd ch1", a1, he1[k]);
                chk("rnd ch2", a2, he2[k]);
                chk("rnd o_de", {9'b0, ade}, {9'b0, hde[k]});
                for (int c = 0; c < 3; c++) begin
                    if (ade) disp[c] += 2 * ones8(sy[c][7:0]) + 2 * int'(sy[c][8])
                                        + 2 * int'(sy[c][9]) - 10;
                    else disp[c] = 0;
                    n_total++;
                    if (disp[c] >= -10 && disp[c] <= 10) n_pass++;
                    else $display("FAIL rnd disparity ch%0d: got %0d, expected within [-10,10]",
                                  c, disp[c]);
                end
                if (hde[k]) begin
                    chk("rnd decode ch0", {2'b0, dec(a0)}, {2'b0, hb[k]});
                    chk("rnd decode ch1", {2'b0, dec(a1)}, {2'b0, hg[k]});
                    chk("rnd decode ch2", {2'b0, dec(a2)}, {2'b0, hr[k]});
                end
            end
            if (t < 10000) begin
                int k;
                logic [9:0] e;
                k = t % 4;
                drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom));
                hde[k] = de; hr[k] = r; hg[k] = g; hb[k] = b;
                model(0, de, {vs, hs}, b, e); he0[k] = e;
                model(1, de, 2'b00,    g, e); he1[k] = e;
                model(2, de, 2'b00,    r, e); he2[k] = e;
            end else begin
                idle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_encoder_rgb.md
# tmds_encoder_rgb

Three-channel DVI/TMDS 8b/10b encoder for the 480p HDMI path. Consumes the pixel-clock RGB888, hsync, vsync and data-enable produced by the 480p timing/pattern stage. Produces three DC-balanced 10-bit TMDS symbols per pixel clock for the 10:1 serializer stage. Implements the DVI 1.0 encoding algorithm with per-channel running-disparity tracking in a fixed 2-stage pipeline.

## Interface
- P_SYNC_INVERT, default 0: when 1, hsync and vsync are inverted before encoding.
- i_pix_clk  in  1  pixel clock (27 MHz); all logic is on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_red  in  8  red pixel, sampled when i_de=1.
- i_green  in  8  green pixel, sampled when i_de=1.
- i_blue  in  8  blue pixel, sampled when i_de=1.
- i_hsync  in  1  horizontal sync.
- i_vsync  in  1  vertical sync.
- i_de  in  1  data enable (1 = active video).
- o_tmds_ch0  out  10  blue channel symbol.
- o_tmds_ch1  out  10  green channel symbol.
- o_tmds_ch2  out  10  red channel symbol.
- o_de  out  1  i_de delayed to align with the symbols.

## Operation
- One identical encoder per channel: ch0 = blue, ch1 = green, ch2 = red.
- Control bits {C1,C0}:
  - ch0: {vsync, hsync} after optional inversion.
  - ch1 and ch2: always 00.
- Stage 1, registered; D is the 8-bit input, N1(x) and N0(x) count ones and zeros:
  - If N1(D)>4, or N1(D)==4 and D[0]==0: XNOR chain. q_m[0]=D[0]; q_m[i]=q_m[i-1] XNOR D[i]; q_m[8]=0.
  - Otherwise: XOR chain, same form with XOR; q_m[8]=1.
  - de and the control bits are registered alongside q_m.
- Stage 2, registered; cnt is a 5-bit signed running disparity per channel, and N1 and N0 are taken over q_m[7:0].
  - de=0: output is the control symbol and cnt is set to 0. Control symbols:
    - 00 -> 10'b1101010100
    - 01 -> 10'b0010101011
    - 10 -> 10'b0101010100
    - 11 -> 10'b1010101011
  - cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - q_m[8]=1: cnt += N1-N0.
    - q_m[8]=0: cnt += N0-N1.
  - (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + N0-N1.
  - Otherwise: out = {0, q_m[8], q_m[7:0]}; cnt += N1-N0 - 2*(~q_m[8]).
- Disparity arithmetic: sign-extend all terms to 5 bits.
  - By construction cnt stays within [-10,+10]; no saturation logic.
  - A 5-bit signed range suffices but must not overflow under any input sequence.
- Disparity is independent per channel. Control periods reset all three cnt registers.

## Timing
- Latency is exactly 2 i_pix_clk cycles. Inputs sampled on edge k appear on the outputs after edge k+2.
- Throughput is one symbol per channel per clock; there are no stalls and no handshake.
- o_de equals i_de delayed by 2 cycles.
- On i_rst_n low, asynchronously and immediately:
  - all o_tmds_chN = 10'b1101010100;
  - o_de=0, all cnt=0;
  - stage-1 registers clear to de=0, ctrl=00.
- Reset release: the first real symbol emerges 2 edges after the first sampled input.
- de falling mid-line: the first control symbol appears 2 cycles later, and cnt is 0 for the next active pixel.
- de rising: the first data symbol is computed from cnt=0.
- Reset asserted mid-line: outputs revert to the reset symbol in the same cycle. No partial symbol is emitted after release.

## Test plan
- Reset, with i_rst_n held low for 3 clocks and arbitrary inputs: all channels read 10'h354 and o_de=0. Release with de=0, hs=vs=0: 10'h354 persists.
- Control encoding, P_SYNC_INVERT=0 and de=0:
  - hs=1, vs=0: ch0 = 10'h0AB two cycles later.
  - hs=0, vs=1: ch0 = 10'h154.
  - hs=1, vs=1: ch0 = 10'h2AB.
  - In all cases ch1 = ch2 = 10'h354.
- Repeat the control cases with P_SYNC_INVERT=1: hs=vs=1 gives ch0 = 10'h354, and hs=vs=0 gives 10'h2AB.
- Disparity sequence: de=1 with rgb=000000 held for 4 cycles from a de=0 period.
  - Each channel emits 10'h100, 10'h3FF, 10'h100, 10'h3FF, starting 2 cycles after de rises.
  - o_de rises in the same cycle as the first 10'h100.
- DE toggle: after the step above, drop de for 1 cycle, then send rgb=000000 again. The first data symbol is 10'h100 again, proving cnt was cleared.
- Data D=FF from cnt=0: ch0 = 10'h200.
- Random pixels for 10k cycles, checked against a reference model of the algorithm:
  - every symbol matches;
  - running disparity stays in [-10,+10];
  - decoding each symbol recovers the input byte.
